// File: rtl/pipeline_dump_tx.sv
// Freezes the pipeline, snapshots PC/cycle count and streams them plus the register file
// as a byte frame (HEADER, PC, CYCLE, REG[0..NUM_REGS-1], MSB first) on a valid/ready port.
`timescale 1ns/1ps
module pipeline_dump_tx #(
    parameter int          NUM_REGS = 32,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] cycle_i,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        ena_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PC,
        CYC,
        FETCH,
        REG,
        DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state;
    logic [1:0]  cnt;
    logic [4:0]  idx;
    logic [31:0] shreg;
    logic [31:0] pc_q;
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx_valid_o <= 1'b0;
            tx_data_o  <= 8'h00;
            reg_addr_o <= 5'd0;
            ena_o      <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            cnt        <= 2'd0;
            idx        <= 5'd0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        pc_q       <= pc_i;
                        cyc_q      <= cycle_i;
                        state      <= HDR;
                        busy_o     <= 1'b1;
                        ena_o      <= 1'b0;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= HEADER;
                        idx        <= 5'd0;
                    end
                end
                HDR: begin
                    if (tx_ready_i) begin
                        state     <= PC;
                        shreg     <= pc_q;
                        tx_data_o <= pc_q[31:24];
                        cnt       <= 2'd0;
                    end
                end
                PC, CYC, REG: begin
                    if (tx_ready_i) begin
                        if (cnt != 2'd3) begin
                            // next byte of the current word comes from the shift register
                            cnt       <= cnt + 2'd1;
                            shreg     <= {shreg[23:0], 8'h00};
                            tx_data_o <= shreg[23:16];
                        end else if (state == PC) begin
                            state     <= CYC;
                            shreg     <= cyc_q;
                            tx_data_o <= cyc_q[31:24];
                            cnt       <= 2'd0;
                        end else if (state == CYC) begin
                            state      <= FETCH;
                            tx_valid_o <= 1'b0;
                            reg_addr_o <= idx;
                        end else if (idx == LAST_IDX) begin
                            state      <= DONE;
                            tx_valid_o <= 1'b0;
                            done_o     <= 1'b1;
                            ena_o      <= 1'b1;
                            busy_o     <= 1'b0;
                        end else begin
                            state      <= FETCH;
                            tx_valid_o <= 1'b0;
                            idx        <= idx + 5'd1;
                            reg_addr_o <= idx + 5'd1;
                        end
                    end
                end
                FETCH: begin
                    // read port is combinational from reg_addr_o, so data is valid now
                    shreg      <= reg_data_i;
                    tx_data_o  <= reg_data_i[31:24];
                    tx_valid_o <= 1'b1;
                    cnt        <= 2'd0;
                    state      <= REG;
                end
                DONE: begin
                    idx   <= 5'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_dump_tx.sv
// Randomised bench for pipeline_dump_tx: a frame-level byte-queue model checked every cycle,
// plus literal expectations for the first frame and its latency.
`timescale 1ns/1ps
module tb_pipeline_dump_tx;

    localparam int NREG  = 32;
    localparam int FLEN  = 9 + 4 * NREG;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] cyc = 32'd0;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        ena;
    logic        busy;
    logic        done;

    logic [31:0] regs [NREG];
    assign reg_data = regs[reg_addr];

    pipeline_dump_tx #(.NUM_REGS(NREG), .HEADER(8'hA5)) dut (
        .clk        (clk),
        .reset      (rst),
        .start_i    (start),
        .pc_i       (pc),
        .cycle_i    (cyc),
        .reg_addr_o (reg_addr),
        .reg_data_i (reg_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .ena_o      (ena),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // model state
    logic [7:0] q[$];
    logic       mbusy = 1'b0, mdone = 1'b0, gap = 1'b0;
    logic       chk_rst = 1'b0, stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         nsent = 0, cyc_cnt = 0, start_cyc = 0, done_lat = 0;
    int         frame_len = 0, done_count = 0, frames_started = 0;
    logic [7:0] fb [FLEN];
    logic [7:0] fb1 [FLEN];
    logic       rmode = 1'b0;
    logic       o_busy, o_done, n_done, n_gap;

    // ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rmode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // compare process
    initial begin
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (chk_rst) begin
                chk("rst_valid", 32'(tx_valid), 32'd0);
                chk("rst_data", 32'(tx_data), 32'd0);
                chk("rst_addr", 32'(reg_addr), 32'd0);
                chk("rst_ena", 32'(ena), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
            end
            chk_rst = rst;
            if (rst) begin
                mbusy = 1'b0; mdone = 1'b0; gap = 1'b0;
                q.delete(); nsent = 0; stall_prev = 1'b0;
            end else begin
                chk("busy", 32'(busy), 32'(mbusy));
                chk("ena", 32'(ena), 32'(!mbusy));
                chk("done", 32'(done), 32'(mdone));
                chk("valid", 32'(tx_valid), 32'(mbusy && !gap));
                if (stall_prev) chk("hold_data", 32'(tx_data), 32'(prev_data));
                if (mbusy && nsent >= 9) chk("reg_addr", 32'(reg_addr), 32'((nsent - 9) / 4));
                if (done) begin
                    done_count++;
                    done_lat = cyc_cnt - start_cyc;
                end
                stall_prev = tx_valid && !tx_ready;
                prev_data  = tx_data;
                o_busy = mbusy; o_done = mdone;
                n_done = 1'b0; n_gap = 1'b0;
                if (o_busy && !gap && tx_ready && q.size() > 0) begin
                    chk("byte", 32'(tx_data), 32'(q[0]));
                    if (nsent < FLEN) fb[nsent] = tx_data;
                    void'(q.pop_front());
                    nsent++;
                    if (q.size() == 0) begin
                        mbusy = 1'b0;
                        n_done = 1'b1;
                        frame_len = nsent;
                    end else if (nsent >= 9 && (nsent - 9) % 4 == 0) begin
                        n_gap = 1'b1;
                    end
                end
                if (start && !o_busy && !o_done) begin
                    q.delete();
                    q.push_back(8'hA5);
                    for (int b = 3; b >= 0; b--) q.push_back(pc[8*b +: 8]);
                    for (int b = 3; b >= 0; b--) q.push_back(cyc[8*b +: 8]);
                    for (int k = 0; k < NREG; k++)
                        for (int b = 3; b >= 0; b--) q.push_back(regs[k][8*b +: 8]);
                    mbusy = 1'b1;
                    nsent = 0;
                    start_cyc = cyc_cnt;
                    frames_started++;
                end
                mdone = n_done;
                gap   = n_gap;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget, input logic jitter);
        int i = 0;
        while (!done && i < budget) begin
            if (jitter) begin
                pc  = $urandom;
                cyc = $urandom;
            end
            tick();
            i++;
        end
        if (i >= budget) timeout(nm);
        tick();
    endtask

    task automatic wait_sent(input string nm, input int n);
        int i = 0;
        while (!(nsent >= n && tx_valid) && i < 2000) begin
            tick();
            i++;
        end
        if (i >= 2000) timeout(nm);
    endtask

    logic [7:0] exp17 [17];
    int         d0, f0;
    int         same;

    initial begin
        exp17 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h19,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
        for (int k = 0; k < NREG; k++) regs[k] = k * 32'h01010101;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // frame with sink always ready
        chk("ena_before", 32'(ena), 32'd1);
        pc = 32'h0000_0040; cyc = 32'd25; rmode = 1'b0;
        pulse_start();
        wait_done("t1_done", 400, 1'b0);
        for (int i = 0; i < 17; i++) chk("t1_lit_byte", 32'(fb[i]), 32'(exp17[i]));
        chk("t1_last_byte", 32'(fb[FLEN-1]), 32'h1F);
        chk("t1_len", 32'(frame_len), 32'd137);
        chk("t1_done_lat", 32'(done_lat), 32'd170);
        chk("t1_ena_after", 32'(ena), 32'd1);
        for (int i = 0; i < FLEN; i++) fb1[i] = fb[i];

        // same frame under random back-pressure
        rmode = 1'b1;
        pulse_start();
        wait_done("t2_done", 3000, 1'b0);
        same = 1;
        for (int i = 0; i < FLEN; i++) if (fb[i] !== fb1[i]) same = 0;
        chk("t2_same_frame", 32'(same), 32'd1);
        chk("t2_len", 32'(frame_len), 32'd137);

        // random registers, pc/cycle changing during the frame
        for (int k = 0; k < NREG; k++) regs[k] = $urandom;
        pc = $urandom; cyc = $urandom;
        pulse_start();
        wait_done("t3_done", 3000, 1'b1);
        chk("t3_len", 32'(frame_len), 32'd137);

        // starts at byte 20 and during DONE are ignored
        rmode = 1'b0;
        d0 = done_count; f0 = frames_started;
        pc = $urandom; cyc = $urandom;
        pulse_start();
        wait_sent("t4_byte20", 20);
        pulse_start();
        begin
            int i = 0;
            while (!done && i < 400) begin
                tick();
                i++;
            end
            if (i >= 400) timeout("t4_done");
        end
        pulse_start();
        repeat (5) tick();
        chk("t4_one_done", 32'(done_count - d0), 32'd1);
        chk("t4_one_frame", 32'(frames_started - f0), 32'd1);
        chk("t4_idle_busy", 32'(busy), 32'd0);

        // reset while byte 50 is presented, then a full frame
        rmode = 1'b1;
        for (int k = 0; k < NREG; k++) regs[k] = $urandom;
        pulse_start();
        wait_sent("t5_byte50", 49);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 32'(tx_valid), 32'd0);
        chk("t5_ena", 32'(ena), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        tick();
        pulse_start();
        wait_done("t5_done", 3000, 1'b0);
        chk("t5_len", 32'(frame_len), 32'd137);
        chk("t5_header", 32'(fb[0]), 32'hA5);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
